// File: rtl/display_trace_render_pkg.sv
// Shared types, default colours and the sample-to-row scaling rule for the trace renderer.
package display_trace_render_pkg;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_CAPTURE,
        ST_RENDER,
        ST_FLIP
    } state_t;

    // Per-pixel render sequence: RAM read, colour compute, request held until ack.
    typedef enum logic [1:0] {
        PH_READ,
        PH_CALC,
        PH_REQ
    } phase_t;

    localparam logic [15:0] COL_BG_DEF   = 16'h0000;
    localparam logic [15:0] COL_GRID_DEF = 16'h2104;
    localparam logic [15:0] COL_CH_DEF   = 16'h667f;

    // Full-scale sample maps to the top row, zero to the bottom row.
    function automatic int unsigned scale_row(input int unsigned s, input int unsigned sw,
                                              input int unsigned h);
        return (h - 1) - ((s * h) >> sw);
    endfunction

endpackage

// File: rtl/display_trace_render_if.sv
// Pixel write request bus towards the SDRAM arbiter.
interface display_trace_render_if;
    logic [23:0] addr;
    logic [15:0] data;
    logic        req;
    logic        wr;
    logic        ack;

    modport master (output addr, output data, output req, output wr, input ack);
    modport slave  (input addr, input data, input req, input wr, output ack);
endinterface

// File: rtl/display_trace_render_col_ram.sv
// Column RAM: one word per captured column holding every channel's row, registered read.
module display_trace_render_col_ram #(
    parameter int DEPTH = 800,
    parameter int WIDTH = 18,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clkSYS,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write on capture, read one cycle behind the render column address.
    always_ff @(posedge clkSYS) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/display_trace_render.sv
// Captures one screen of multi-channel samples, renders it into the hidden framebuffer page
// pixel by pixel, then flips the page once the display controller has released it.
module display_trace_render
    import display_trace_render_pkg::*;
#(
    parameter logic [23:0]      BASE     = 24'h0,
    parameter logic [23:0]      PAGE     = 24'h080000,
    parameter int               W        = 800,
    parameter int               H        = 480,
    parameter int               CH       = 2,
    parameter int               SW       = 10,
    parameter int               GRID     = 50,
    parameter logic [15:0]      COL_BG   = COL_BG_DEF,
    parameter logic [15:0]      COL_GRID = COL_GRID_DEF,
    parameter logic [CH*16-1:0] COL_CH   = {CH{COL_CH_DEF}}
) (
    input  logic                 clkSYS,
    input  logic                 n_reset,
    input  logic [CH*SW-1:0]     smpl_data,
    input  logic                 smpl_valid,
    output logic                 smpl_ready,
    input  logic [CH-1:0]        ch_en,
    input  logic                 vec_mode,
    output logic                 swap,
    input  logic                 stat,
    display_trace_render_if.master wbus
);

    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int PW = (W * H > 1) ? $clog2(W * H) : 1;

    state_t             state_q, state_d;
    phase_t             ph_q;
    logic               swap_q, ready_q, vec_q;
    logic [CH-1:0]      chen_q;
    logic [XW-1:0]      cap_x_q, x_q;
    logic [RW-1:0]      y_q;
    logic [PW-1:0]      pix_q;
    logic [15:0]        gx_q, gy_q;
    logic [CH*RW-1:0]   wrow, row_p1, prev_q;
    logic [CH-1:0]      hit;
    logic [15:0]        pix_col;
    logic               on_grid, acc, cap_last, pix_last, ack_hit;
    logic               req_q;
    logic [23:0]        addr_q;
    logic [15:0]        data_q;

    assign acc      = smpl_valid && ready_q && (state_q == ST_CAPTURE);
    assign cap_last = (cap_x_q == XW'(W - 1));
    assign pix_last = (pix_q == PW'(W * H - 1));
    assign ack_hit  = req_q && wbus.ack;
    assign on_grid  = (GRID != 0) && ((gx_q == '0) || (gy_q == '0));

    assign smpl_ready = ready_q;
    assign swap       = swap_q;
    assign wbus.req   = req_q;
    assign wbus.addr  = addr_q;
    assign wbus.data  = data_q;
    assign wbus.wr    = 1'b1;

    // Capture stage: sample -> row per channel, written straight into the column RAM.
    for (genvar gc = 0; gc < CH; gc++) begin : g_ch
        logic [RW-1:0] cur, prv, lo, hi;
        assign wrow[RW*gc +: RW] = RW'(scale_row(32'(smpl_data[SW*gc +: SW]), 32'(SW), 32'(H)));
        assign cur     = row_p1[RW*gc +: RW];
        assign prv     = (x_q == '0) ? cur : prev_q[RW*gc +: RW];
        assign lo      = (prv < cur) ? prv : cur;
        assign hi      = (prv < cur) ? cur : prv;
        assign hit[gc] = chen_q[gc] && (vec_q ? ((y_q >= lo) && (y_q <= hi)) : (y_q == cur));
    end

    display_trace_render_col_ram #(
        .DEPTH (W),
        .WIDTH (CH * RW),
        .AW    (XW)
    ) u_col_ram (
        .clkSYS (clkSYS),
        .we     (acc),
        .waddr  (cap_x_q),
        .wdata  (wrow),
        .raddr  (x_q),
        .rdata  (row_p1)
    );

    // Next-state logic for the capture/render/flip sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT:    if (stat == swap_q)         state_d = ST_CAPTURE;
            ST_CAPTURE: if (acc && cap_last)        state_d = ST_RENDER;
            ST_RENDER:  if (ack_hit && pix_last)    state_d = ST_FLIP;
            ST_FLIP:                                state_d = ST_WAIT;
            default:                                state_d = ST_WAIT;
        endcase
    end

    // Lowest-index hitting channel wins over grid, grid wins over background.
    always_comb begin
        pix_col = on_grid ? COL_GRID : COL_BG;
        for (int c = CH - 1; c >= 0; c--)
            if (hit[c])
                pix_col = COL_CH[16*c +: 16];
    end

    // State register, page toggle, capture column and the settings latched for rendering.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_WAIT;
            swap_q  <= 1'b0;
            ready_q <= 1'b0;
            cap_x_q <= '0;
            chen_q  <= '0;
            vec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_CAPTURE);
            if (state_q == ST_FLIP)
                swap_q <= ~swap_q;
            if (state_q != ST_CAPTURE)
                cap_x_q <= '0;
            else if (acc)
                cap_x_q <= cap_x_q + 1'b1;
            if (acc && cap_last) begin
                chen_q <= ch_en;
                vec_q  <= vec_mode;
            end
        end
    end

    // Render scan: read column, compute colour, hold the request until acked, then advance.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            ph_q   <= PH_READ;
            x_q    <= '0;
            y_q    <= '0;
            pix_q  <= '0;
            gx_q   <= '0;
            gy_q   <= '0;
            req_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (state_q != ST_RENDER) begin
            ph_q  <= PH_READ;
            x_q   <= '0;
            y_q   <= '0;
            pix_q <= '0;
            gx_q  <= '0;
            gy_q  <= '0;
            req_q <= 1'b0;
        end else begin
            unique case (ph_q)
                // Stage boundary: RAM output for column x becomes valid next cycle.
                PH_READ: ph_q <= PH_CALC;
                // Stage boundary: colour registered onto the request bus.
                PH_CALC: begin
                    req_q  <= 1'b1;
                    addr_q <= BASE + (swap_q ? 24'h0 : PAGE) + 24'(pix_q);
                    data_q <= pix_col;
                    ph_q   <= PH_REQ;
                end
                PH_REQ: if (wbus.ack) begin
                    req_q <= 1'b0;
                    ph_q  <= PH_READ;
                    pix_q <= pix_q + 1'b1;
                    if (x_q == XW'(W - 1)) begin
                        x_q  <= '0;
                        gx_q <= '0;
                        y_q  <= y_q + 1'b1;
                        gy_q <= (gy_q == 16'(GRID - 1)) ? 16'd0 : gy_q + 16'd1;
                    end else begin
                        x_q  <= x_q + 1'b1;
                        gx_q <= (gx_q == 16'(GRID - 1)) ? 16'd0 : gx_q + 16'd1;
                    end
                end
                default: ph_q <= PH_READ;
            endcase
        end
    end

    // Previous-column rows for vector mode; pure data, no reset needed.
    always_ff @(posedge clkSYS) begin
        if (state_q == ST_RENDER && ph_q == PH_CALC)
            prev_q <= row_p1;
    end

endmodule

// File: tb/tb_display_trace_render.sv
// Randomized scoreboard bench: two renderer instances (no grid / grid 4) share stimulus;
// expected frames are computed from the rendering rules and checked as pixels are acked.
module tb_display_trace_render;

    localparam int W = 16, H = 8, CH = 2, SW = 4, NPIX = W * H;
    localparam logic [23:0] BASE = 24'h000100, PAGE = 24'h080000;
    localparam logic [15:0] CBG = 16'h0841, CGRID = 16'h2104, C0 = 16'h07E0, C1 = 16'hF800;

    typedef struct packed { logic [23:0] a; logic [15:0] d; } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             n_reset;
    logic [CH*SW-1:0] smpl_data;
    logic             smpl_valid;
    logic [CH-1:0]    ch_en;
    logic             vec_mode, stat, ack_r;
    logic             rdy_a, rdy_b, swap_a, swap_b;

    display_trace_render_if bus_a ();
    display_trace_render_if bus_b ();
    assign bus_a.ack = ack_r;
    assign bus_b.ack = ack_r;

    display_trace_render #(.BASE(BASE), .PAGE(PAGE), .W(W), .H(H), .CH(CH), .SW(SW), .GRID(0),
        .COL_BG(CBG), .COL_GRID(CGRID), .COL_CH({C1, C0})) dut_a (
        .clkSYS(clk), .n_reset(n_reset), .smpl_data(smpl_data), .smpl_valid(smpl_valid),
        .smpl_ready(rdy_a), .ch_en(ch_en), .vec_mode(vec_mode), .swap(swap_a), .stat(stat),
        .wbus(bus_a));

    display_trace_render #(.BASE(BASE), .PAGE(PAGE), .W(W), .H(H), .CH(CH), .SW(SW), .GRID(4),
        .COL_BG(CBG), .COL_GRID(CGRID), .COL_CH({C1, C0})) dut_b (
        .clkSYS(clk), .n_reset(n_reset), .smpl_data(smpl_data), .smpl_valid(smpl_valid),
        .smpl_ready(rdy_b), .ch_en(ch_en), .vec_mode(vec_mode), .swap(swap_b), .stat(stat),
        .wbus(bus_b));

    exp_t          qa[$], qb[$];
    exp_t          me;
    int            checks = 0, fails = 0;
    int            ack_cnt = 0, hold_at = -1, stall = 0;
    int            samp[CH][W];
    logic [CH-1:0] m_chen;
    logic          m_vec, m_swap;
    logic          p_req, p_ack;
    logic [23:0]   p_addr;
    logic [15:0]   p_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic give_up(input string nm);
        checks++;
        fails++;
        $display("FAIL timeout waiting for %s", nm);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    endtask

    function automatic int row_of(input int s);
        return (H - 1) - (s * H) / (1 << SW);
    endfunction

    function automatic logic [15:0] model_pix(input int x, input int y, input int grid);
        for (int c = 0; c < CH; c++) begin
            if (m_chen[c]) begin
                int r  = row_of(samp[c][x]);
                int p  = (x == 0) ? r : row_of(samp[c][x-1]);
                int lo = (p < r) ? p : r;
                int hi = (p < r) ? r : p;
                if (m_vec ? (y >= lo && y <= hi) : (y == r))
                    return (c == 0) ? C0 : C1;
            end
        end
        if (grid != 0 && ((x % grid) == 0 || (y % grid) == 0))
            return CGRID;
        return CBG;
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                e.a = BASE + (m_swap ? 24'h0 : PAGE) + 24'(y * W + x);
                e.d = model_pix(x, y, 0);
                qa.push_back(e);
                e.d = model_pix(x, y, 4);
                qb.push_back(e);
            end
    endtask

    // Monitor / ack driver: acts on the falling edge while the request bus is stable.
    always @(negedge clk) begin
        if (!n_reset) begin
            ack_r = 1'($urandom_range(0, 1));
            p_req = 1'b0;
            p_ack = 1'b0;
        end else begin
            if (p_req && !p_ack) begin
                chk("hold_req", 32'(bus_a.req), 32'(1));
                chk("hold_addr", 32'(bus_a.addr), 32'(p_addr));
                chk("hold_data", 32'(bus_a.data), 32'(p_data));
            end
            if (p_req && p_ack)
                chk("req_drop", 32'(bus_a.req), 32'(0));
            if (bus_a.req) begin
                if (ack_cnt == hold_at && stall < 20) begin
                    ack_r = 1'b0;
                    stall++;
                end else
                    ack_r = ($urandom_range(0, 3) != 0);
            end else
                ack_r = ($urandom_range(0, 3) == 0);
            if (ack_r && bus_a.req) begin
                chk("sb_a_pending", 32'(qa.size() != 0), 32'(1));
                if (qa.size() != 0) begin
                    me = qa.pop_front();
                    chk("addr_a", 32'(bus_a.addr), 32'(me.a));
                    chk("data_a", 32'(bus_a.data), 32'(me.d));
                end
                ack_cnt++;
            end
            if (ack_r && bus_b.req) begin
                chk("sb_b_pending", 32'(qb.size() != 0), 32'(1));
                if (qb.size() != 0) begin
                    me = qb.pop_front();
                    chk("addr_b", 32'(bus_b.addr), 32'(me.a));
                    chk("data_b", 32'(bus_b.data), 32'(me.d));
                end
            end
            p_req  = bus_a.req;
            p_addr = bus_a.addr;
            p_data = bus_a.data;
            p_ack  = ack_r;
        end
    end

    task automatic capture_frame(input logic [CH-1:0] en, input logic vm);
        int idx = 0;
        int guard = 0;
        ch_en  = en;
        vec_mode = vm;
        m_chen = en;
        m_vec  = vm;
        ack_cnt = 0;
        while (idx < W) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) give_up("capture");
            smpl_valid = ($urandom_range(0, 3) != 0);
            smpl_data  = {SW'(samp[1][idx]), SW'(samp[0][idx])};
            if (smpl_valid && rdy_a) idx++;
        end
        @(negedge clk);
        smpl_valid = 1'b0;
        push_expected();
    endtask

    task automatic finish_frame();
        int   guard = 0;
        logic old = swap_a;
        while (swap_a == old) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) give_up("render");
            smpl_valid = 1'($urandom_range(0, 1));
            smpl_data  = (CH*SW)'($urandom);
            ch_en      = CH'($urandom);
            vec_mode   = 1'($urandom);
        end
        smpl_valid = 1'b0;
        m_swap = ~m_swap;
        chk("swap_a", 32'(swap_a), 32'(m_swap));
        chk("swap_b", 32'(swap_b), 32'(m_swap));
        chk("ack_count", 32'(ack_cnt), 32'(NPIX));
        chk("sb_a_drained", 32'(qa.size()), 32'(0));
        chk("sb_b_drained", 32'(qb.size()), 32'(0));
    endtask

    task automatic rand_samples();
        for (int x = 0; x < W; x++)
            for (int c = 0; c < CH; c++)
                samp[c][x] = $urandom_range(0, (1 << SW) - 1);
    endtask

    initial begin
        int guard;
        n_reset = 1'b0; stat = 1'b0; smpl_valid = 1'b0; smpl_data = '0;
        ch_en = '0; vec_mode = 1'b0; ack_r = 1'b0; m_swap = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_swap", 32'(swap_a), 32'(0));
        chk("rst_req", 32'(bus_a.req), 32'(0));
        chk("rst_ready_a", 32'(rdy_a), 32'(0));
        chk("rst_ready_b", 32'(rdy_b), 32'(0));
        chk("rst_addr", 32'(bus_a.addr), 32'(0));
        chk("wr_const", 32'(bus_a.wr), 32'(1));
        n_reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(rdy_a), 32'(1));

        // Dot mode, channel 0 ramp, backpressure stall on pixel 10.
        rand_samples();
        for (int x = 0; x < W; x++) samp[0][x] = x;
        hold_at = 10; stall = 0;
        capture_frame(2'b01, 1'b0);
        finish_frame();
        chk("stall_done", 32'(stall), 32'(20));

        // Display still scanning the old page: nothing may start.
        repeat (10) @(negedge clk);
        chk("blocked_ready", 32'(rdy_a), 32'(0));
        chk("blocked_req", 32'(bus_a.req), 32'(0));
        hold_at = -1;
        stat = m_swap;

        // Vector mode, steep edge between columns 0 and 1.
        rand_samples();
        samp[0][0] = 0; samp[0][1] = 15;
        capture_frame(2'b01, 1'b1);
        finish_frame();
        stat = m_swap;

        // Channel priority on an overlapping row, then channel 1 alone.
        for (int x = 0; x < W; x++) begin samp[0][x] = 8; samp[1][x] = 8; end
        capture_frame(2'b11, 1'b0);
        finish_frame();
        stat = m_swap;
        capture_frame(2'b10, 1'b0);
        finish_frame();
        stat = m_swap;

        // Random traces.
        rand_samples();
        capture_frame(CH'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        finish_frame();
        stat = m_swap;

        // Reset in the middle of rendering (page select is 1 here).
        rand_samples();
        capture_frame(2'b11, 1'b1);
        guard = 0;
        while (ack_cnt < 50) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) give_up("pixel 50");
        end
        #2 n_reset = 1'b0;
        #1;
        chk("midrst_req", 32'(bus_a.req), 32'(0));
        chk("midrst_swap", 32'(swap_a), 32'(0));
        chk("midrst_ready", 32'(rdy_a), 32'(0));
        qa.delete();
        qb.delete();
        m_swap = 1'b0;
        stat = 1'b0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        ack_cnt = 0;

        // Fresh frame after reset lands back on the page-0 offset.
        rand_samples();
        capture_frame(CH'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        finish_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        checks++;
        fails++;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
